// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register-write target: FSM states, default address, R/W bit values.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RACK,
    WAIT_STOP
  } state_e;

  localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h2A;
  localparam logic       RW_WRITE         = 1'b0;
  localparam logic       RW_READ          = 1'b1;

endpackage

// File: rtl/i2c_sync_filter.sv
// Two-flop synchronizer for one bus pin, followed by an optional stable-sample glitch filter
// (enabled from the top when I2C_GLITCH_FILTER_EN is defined). Resets to the idle-bus level 1.
module i2c_sync_filter #(
  parameter bit          FILT_EN  = 1'b0,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], pin_i};
    end
  end

  if (FILT_EN && (FILT_LEN > 0)) begin : gFilt
    localparam int CntW = $clog2(FILT_LEN + 1);

    logic [CntW-1:0] cnt_q;
    logic            level_q;

    // A new level is only accepted once it has been seen FILT_LEN times in a row.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        level_q <= 1'b1;
      end else if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FILT_LEN - 1)) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end

    assign level_o = level_q;
  end else begin : gBypass
    assign level_o = sync_q[1];
  end

endmodule

// File: rtl/i2c_target.sv
// I2C target that writes/reads a downstream register file through an auto-incrementing pointer.
// Define I2C_GLITCH_FILTER_EN to add the SCL_FILT-sample glitch filter after each synchronizer.
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT,
  parameter int unsigned SCL_FILT = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       wr_en,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [7:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       busy
);

`ifdef I2C_GLITCH_FILTER_EN
  localparam bit FiltEn = 1'b1;
`else
  localparam bit FiltEn = 1'b0;
`endif

  logic scl;
  logic sda;

  i2c_sync_filter #(.FILT_EN(FiltEn), .FILT_LEN(SCL_FILT)) uSclSync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (scl_in),
    .level_o (scl)
  );

  i2c_sync_filter #(.FILT_EN(FiltEn), .FILT_LEN(SCL_FILT)) uSdaSync (
    .clk     (clk),
    .rst     (rst),
    .pin_i   (sda_in),
    .level_o (sda)
  );

  state_e     state_q, state_d;
  logic       sclPrev_q, sdaPrev_q;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] ptr_q, ptr_d;
  logic       rw_q, rw_d;
  logic       sdaOe_q, sdaOe_d;
  logic       wrEn_q, wrEn_d;
  logic [7:0] wrAddr_q, wrAddr_d;
  logic [7:0] wrData_q, wrData_d;
  logic       busy_q, busy_d;

  logic       sclRise, sclFall, startDet, stopDet, lastBit;
  logic [7:0] rxByte;

  assign sclRise  = scl & ~sclPrev_q;
  assign sclFall  = ~scl & sclPrev_q;
  assign startDet = scl & sclPrev_q & sdaPrev_q & ~sda;
  assign stopDet  = scl & sclPrev_q & ~sdaPrev_q & sda;
  assign rxByte   = {shift_q[6:0], sda};
  assign lastBit  = (bitCnt_q == 3'd7);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    bitCnt_d = bitCnt_q;
    ptr_d    = ptr_q;
    rw_d     = rw_q;
    sdaOe_d  = sdaOe_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    busy_d   = busy_q;

    if (stopDet) begin
      state_d = IDLE;
      sdaOe_d = 1'b0;
      busy_d  = 1'b0;
    end else if (startDet) begin
      state_d  = ADDR;
      bitCnt_d = 3'd0;
      sdaOe_d  = 1'b0;
      busy_d   = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (sclRise) begin
          shift_d  = rxByte;
          bitCnt_d = bitCnt_q + 3'd1;
          if (lastBit) begin
            if (rxByte[7:1] == DEV_ADDR) begin
              rw_d    = rxByte[0];
              state_d = ADDR_ACK;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end

        PTR: if (sclRise) begin
          shift_d  = rxByte;
          bitCnt_d = bitCnt_q + 3'd1;
          if (lastBit) begin
            ptr_d   = rxByte;
            state_d = PTR_ACK;
          end
        end

        WDATA: if (sclRise) begin
          shift_d  = rxByte;
          bitCnt_d = bitCnt_q + 3'd1;
          if (lastBit) begin
            wrEn_d   = 1'b1;
            wrAddr_d = ptr_q;
            wrData_d = rxByte;
            ptr_d    = ptr_q + 8'd1;
            state_d  = WDATA_ACK;
          end
        end

        // First SCL fall after the 8th bit starts the ACK, the second one ends it.
        ADDR_ACK, PTR_ACK, WDATA_ACK: if (sclFall) begin
          if (!sdaOe_q) begin
            sdaOe_d = 1'b1;
          end else begin
            sdaOe_d  = 1'b0;
            bitCnt_d = 3'd0;
            if (state_q == ADDR_ACK && rw_q == RW_READ) begin
              shift_d = rd_data;
              sdaOe_d = ~rd_data[7];
              state_d = RDATA;
            end else if (state_q == ADDR_ACK) begin
              state_d = PTR;
            end else begin
              state_d = WDATA;
            end
          end
        end

        RDATA: if (sclFall) begin
          if (lastBit) begin
            sdaOe_d  = 1'b0;
            bitCnt_d = 3'd0;
            state_d  = RACK;
          end else begin
            shift_d  = {shift_q[6:0], 1'b1};
            sdaOe_d  = ~shift_q[6];
            bitCnt_d = bitCnt_q + 3'd1;
          end
        end

        // The pointer moves past every byte sent, so it ends one past the last byte read.
        RACK: begin
          if (sclRise) begin
            ptr_d = ptr_q + 8'd1;
            if (sda) begin
              state_d = WAIT_STOP;
            end
          end else if (sclFall) begin
            shift_d  = rd_data;
            sdaOe_d  = ~rd_data[7];
            bitCnt_d = 3'd0;
            state_d  = RDATA;
          end
        end

        IDLE, WAIT_STOP: ;

        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sclPrev_q <= 1'b1;
      sdaPrev_q <= 1'b1;
      shift_q   <= 8'hFF;
      bitCnt_q  <= 3'h7;
      ptr_q     <= 8'h00;
      rw_q      <= RW_WRITE;
      sdaOe_q   <= 1'b0;
      wrEn_q    <= 1'b0;
      wrAddr_q  <= 8'h00;
      wrData_q  <= 8'h00;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sclPrev_q <= scl;
      sdaPrev_q <= sda;
      shift_q   <= shift_d;
      bitCnt_q  <= bitCnt_d;
      ptr_q     <= ptr_d;
      rw_q      <= rw_d;
      sdaOe_q   <= sdaOe_d;
      wrEn_q    <= wrEn_d;
      wrAddr_q  <= wrAddr_d;
      wrData_q  <= wrData_d;
      busy_q    <= busy_d;
    end
  end

  assign sda_oe  = sdaOe_q;
  assign wr_en   = wrEn_q;
  assign wr_addr = wrAddr_q;
  assign wr_data = wrData_q;
  assign rd_addr = ptr_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: a bit-level bus controller issues directed transactions while scoreboard
// monitors compare ACK/read bytes and register-file writes against hand-computed expectations.
module tb_i2c_target;
  import i2c_pkg::*;

  localparam int Q = 10;

  typedef struct {
    string      name;
    logic [7:0] val;
  } rxExp_t;

  typedef struct {
    string      name;
    logic [7:0] addr;
    logic [7:0] data;
  } wrExp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sclDrv = 1'b1;
  logic       sdaDrv = 1'b1;
  logic       sdaBus;
  logic       sdaOe, wrEn, busy;
  logic [7:0] wrAddr, wrData, rdAddr, rdData;
  logic [7:0] mem [256];

  rxExp_t     expRxQ[$];
  logic [7:0] obsRxQ[$];
  wrExp_t     expWrQ[$];
  wrExp_t     we;

  int checks = 0;
  int errors = 0;
  int oeSeen = 0;

  assign sdaBus = sdaDrv & ~sdaOe;
  assign rdData = mem[rdAddr];

  always #5 clk = ~clk;

  i2c_target dut (
    .clk     (clk),
    .rst     (rst),
    .scl_in  (sclDrv),
    .sda_in  (sdaBus),
    .sda_oe  (sdaOe),
    .wr_en   (wrEn),
    .wr_addr (wrAddr),
    .wr_data (wrData),
    .rd_addr (rdAddr),
    .rd_data (rdData),
    .busy    (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic quarter();
    repeat (Q) @(posedge clk);
    #1;
  endtask

  task automatic busStart();
    sdaDrv = 1'b1; quarter();
    sclDrv = 1'b1; quarter();
    sdaDrv = 1'b0; quarter();
    sclDrv = 1'b0; quarter();
  endtask

  task automatic busStop();
    sdaDrv = 1'b0; quarter();
    sclDrv = 1'b1; quarter();
    sdaDrv = 1'b1; quarter();
  endtask

  task automatic writeBit(input logic b);
    sdaDrv = b;    quarter();
    sclDrv = 1'b1; quarter();
    quarter();
    sclDrv = 1'b0; quarter();
  endtask

  task automatic readBit(output logic b);
    sdaDrv = 1'b1; quarter();
    sclDrv = 1'b1; quarter();
    b = sdaBus;    quarter();
    sclDrv = 1'b0; quarter();
  endtask

  task automatic sendByte(input logic [7:0] b, input logic expAck, input string name);
    logic a;
    expRxQ.push_back('{name, {7'd0, expAck}});
    for (int i = 7; i >= 0; i--) writeBit(b[i]);
    readBit(a);
    obsRxQ.push_back({7'd0, a});
  endtask

  task automatic recvByte(input logic ack, input logic [7:0] expByte, input string name);
    logic [7:0] v;
    logic       b;
    expRxQ.push_back('{name, expByte});
    for (int i = 7; i >= 0; i--) begin
      readBit(b);
      v[i] = b;
    end
    writeBit(ack);
    obsRxQ.push_back(v);
  endtask

  task automatic applyStimulus(input int testId);
    case (testId)
      1: begin
        expWrQ.push_back('{"write 03", 8'h03, 8'hA5});
        busStart();
        sendByte(8'h54, 1'b0, "wr addr ack");
        sendByte(8'h03, 1'b0, "wr ptr ack");
        sendByte(8'hA5, 1'b0, "wr data ack");
        checkOutput("busy in transfer", busy, 1'b1);
        busStop();
        quarter();
        checkOutput("ptr after write", rdAddr, 8'h04);
        checkOutput("busy after stop", busy, 1'b0);
      end
      2: begin
        oeSeen = 0;
        busStart();
        sendByte(8'h56, 1'b1, "mismatch addr nack");
        sendByte(8'h00, 1'b1, "mismatch byte nack");
        busStop();
        quarter();
        checkOutput("mismatch oe count", 32'(oeSeen), 32'd0);
        checkOutput("mismatch ptr kept", rdAddr, 8'h04);
      end
      3: begin
        busStart();
        sendByte(8'h54, 1'b0, "sr addr ack");
        sendByte(8'h10, 1'b0, "sr ptr ack");
        busStart();
        sendByte(8'h55, 1'b0, "rd addr ack");
        recvByte(1'b0, 8'hC3, "rd byte 10");
        recvByte(1'b1, 8'h3C, "rd byte 11");
        busStop();
        quarter();
        checkOutput("ptr after read", rdAddr, 8'h12);
      end
      4: begin
        expWrQ.push_back('{"wrap ff", 8'hFF, 8'h11});
        expWrQ.push_back('{"wrap 00", 8'h00, 8'h22});
        busStart();
        sendByte(8'h54, 1'b0, "wrap addr ack");
        sendByte(8'hFF, 1'b0, "wrap ptr ack");
        sendByte(8'h11, 1'b0, "wrap d0 ack");
        sendByte(8'h22, 1'b0, "wrap d1 ack");
        busStop();
        quarter();
        checkOutput("ptr after wrap", rdAddr, 8'h01);
      end
      5: begin
        busStart();
        sendByte(8'h54, 1'b0, "part addr ack");
        sendByte(8'h40, 1'b0, "part ptr ack");
        writeBit(1'b1);
        writeBit(1'b0);
        writeBit(1'b1);
        writeBit(1'b0);
        busStop();
        quarter();
        checkOutput("partial busy", busy, 1'b0);
        checkOutput("partial state idle", 32'(dut.state_q), 32'(IDLE));
        checkOutput("partial ptr kept", rdAddr, 8'h40);
      end
      6: begin
        busStart();
        sendByte(8'h55, 1'b0, "rst rd addr ack");
        checkOutput("oe before reset", sdaOe, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("oe in reset", sdaOe, 1'b0);
        checkOutput("busy in reset", busy, 1'b0);
        checkOutput("rd_addr in reset", rdAddr, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        quarter();
        expWrQ.push_back('{"post rst write", 8'h20, 8'h3C});
        busStart();
        sendByte(8'h54, 1'b0, "post rst addr ack");
        sendByte(8'h20, 1'b0, "post rst ptr ack");
        sendByte(8'h3C, 1'b0, "post rst data ack");
        busStop();
        quarter();
        checkOutput("ptr after post rst write", rdAddr, 8'h21);
      end
      default: ;
    endcase
  endtask

  initial begin : rxChecker
    rxExp_t     e;
    logic [7:0] o;
    forever begin
      wait (obsRxQ.size() > 0);
      o = obsRxQ.pop_front();
      if (expRxQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected rx: got 0x%0h, expected nothing", o);
      end else begin
        e = expRxQ.pop_front();
        checkOutput(e.name, o, e.val);
      end
    end
  end

  always @(negedge clk) begin
    if (wrEn) begin
      if (expWrQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected wr_en: got addr 0x%0h data 0x%0h, expected none", wrAddr, wrData);
      end else begin
        we = expWrQ.pop_front();
        checkOutput({we.name, " addr"}, wrAddr, we.addr);
        checkOutput({we.name, " data"}, wrData, we.data);
      end
    end
  end

  always @(negedge clk) begin
    if (sdaOe) oeSeen++;
  end

  initial begin : watchdog
    #400000;
    errors++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'hC3;
    mem[8'h11] = 8'h3C;
    mem[8'h40] = 8'h5A;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset sda_oe", sdaOe, 1'b0);
    checkOutput("reset wr_en", wrEn, 1'b0);
    checkOutput("reset wr_addr", wrAddr, 8'h00);
    checkOutput("reset wr_data", wrData, 8'h00);
    checkOutput("reset rd_addr", rdAddr, 8'h00);
    checkOutput("reset busy", busy, 1'b0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    for (int t = 1; t <= 6; t++) applyStimulus(t);

    repeat (40) @(posedge clk);
    #1;
    checkOutput("wr queue drained", 32'(expWrQ.size()), 32'd0);
    checkOutput("rx queue drained", 32'(expRxQ.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 7'h2A, the 7-bit I2C target address the block responds to.
REQ-002 SHALL have parameter SCL_FILT, default 3, the stable-sample count used when the filter of REQ-031 is compiled in.
REQ-003 SHALL have port clk  input  1  system clock; all flops on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port scl_in  input  1  raw SCL pin level, asynchronous to clk.
REQ-006 SHALL have port sda_in  input  1  raw SDA pin level, asynchronous to clk.
REQ-007 SHALL have port sda_oe  output  1  open-drain pull-low: 1 drives SDA low, 0 releases it; pad output data is tied 0.
REQ-008 SHALL have port wr_en  output  1  one-clk write strobe to the downstream sine-generator register file.
REQ-009 SHALL have port wr_addr  output  8  register address qualified by wr_en.
REQ-010 SHALL have port wr_data  output  8  register data qualified by wr_en.
REQ-011 SHALL have port rd_addr  output  8  current register pointer, for a combinational register-file read.
REQ-012 SHALL have port rd_data  input  8  register-file read data for rd_addr, valid in the same cycle.
REQ-013 SHALL have port busy  output  1  high from an accepted START until the next STOP.

Function
REQ-014 SHALL pass scl_in and sda_in through 2-flop synchronizers; every edge and condition below is detected on the synchronized signals.
REQ-015 SHALL detect START (and repeated START) as SDA falling while SCL is high, and STOP as SDA rising while SCL is high.
REQ-016 SHALL sample SDA on SCL rising edges, MSB first, and change sda_oe only on SCL falling edges.
REQ-017 SHALL implement these FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RACK, WAIT_STOP.
REQ-018 SHALL on START enter ADDR from any state and clear the bit counter.
REQ-019 SHALL, after 8 address bits, enter ADDR_ACK and drive ACK low if addr[7:1]==DEV_ADDR; otherwise it SHALL release SDA and enter WAIT_STOP.
REQ-020 SHALL, after a write ACK, take the first byte as the register pointer (PTR, then PTR_ACK with ACK driven).
REQ-021 SHALL treat every following byte as data: on the 8th SCL rise it SHALL pulse wr_en for one clk with wr_addr=pointer and wr_data=byte, ACK the byte, and increment the pointer after the pulse.
REQ-022 SHALL, after a read ACK, load rd_data into the shift register on the SCL falling edge that ends the ACK bit, then shift it out MSB first.
REQ-023 SHALL in RACK sample the controller's bit: on ACK (0) it SHALL increment the pointer and load the next byte; on NACK (1) it SHALL release SDA and enter WAIT_STOP.
REQ-024 SHALL wrap the pointer from 8'hFF to 8'h00.
REQ-025 SHALL on STOP in any state release SDA, discard any partial byte (no wr_en), and enter IDLE.
REQ-026 SHALL keep the pointer across transactions, so a read without a pointer byte continues from the last pointer.
REQ-027 SHALL, when START and STOP are both detected in one clk, give STOP priority.

Reset
REQ-028 SHALL on rst reset the FSM to IDLE, the pointer to 0, and the shift register, bit counter and synchronizers to 1 (idle bus).
REQ-029 SHALL hold sda_oe=0, wr_en=0, wr_addr=0, wr_data=0, rd_addr=0 and busy=0 while rst is high.
REQ-030 SHALL, after rst deasserts mid-transfer, ignore bus activity until the next START.

Configuration
REQ-031 SHALL, with I2C_GLITCH_FILTER_EN defined, add a filter after each synchronizer that accepts a new level only after SCL_FILT consecutive equal samples, adding SCL_FILT clks of latency.
REQ-032 SHALL, without I2C_GLITCH_FILTER_EN, use the 2-flop synchronizer output directly.

Structure
REQ-033 SHALL place the FSM state enum typedef, the DEV_ADDR default and the R/W bit constants in shared package i2c_pkg.
REQ-034 SHALL implement the synchronizer plus optional filter as one sub-module, i2c_sync_filter, instantiated once for SCL and once for SDA.

Verification
REQ-035 SHALL cover a write: START, 0x54, 0x03, 0xA5, STOP -> three ACKs, one wr_en with wr_addr=0x03 and wr_data=0xA5, pointer=0x04.
REQ-036 SHALL cover an address mismatch: START, 0x56, 0x00, STOP -> sda_oe never asserted and no wr_en.
REQ-037 SHALL cover a repeated-START read: START, 0x54, 0x10, Sr, 0x55, read 2 bytes with ACK then NACK, STOP -> bytes are rd_data@0x10 and rd_data@0x11, and rd_addr ends at 0x12.
REQ-038 SHALL cover pointer wrap: write pointer 0xFF, then data 0x11 and 0x22 -> wr_addr 0xFF then 0x00.
REQ-039 SHALL cover STOP mid-byte after 4 data bits -> no wr_en, FSM in IDLE, busy=0.
REQ-040 SHALL cover rst mid-read while sda_oe=1 -> sda_oe=0 immediately, and the next full write transaction succeeds.
